fp_mul: RTL and testbench
=========================

# fp_mul

Multi-cycle IEEE-754 single-precision floating-point multiplier with selectable rounding mode and a start/done handshake. A product is computed in a short internal pipeline driven by a small state machine, then held on `result` until the next operation. It serves as an arithmetic primitive for the face-verification datapath on the SoC-FPGA fabric.

## Interface
- `D_LEN`, default 32: operand/result width; only 32 (8-bit exponent, 23-bit fraction, bias 127) is supported.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle request; sampled only in IDLE.
- `A`  input  D_LEN  operand A, IEEE-754 single.
- `B`  input  D_LEN  operand B, IEEE-754 single.
- `round_mode`  input  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +Inf, 11 toward −Inf.
- `result`  output  D_LEN  registered product; holds its value until the next completion.
- `done`  output  1  registered; high for exactly one cycle when `result` updates.

## Operation
- The FSM register is named `state`, with states IDLE → STAGE1 → STAGE2 → STAGE3 → IDLE.
- **IDLE**
  - If `start`=1, latch `A`, `B` and `round_mode`, then go to STAGE1.
  - Otherwise remain in IDLE.
- **STAGE1: unpack, classify and multiply.**
  - `stage1_sign` = sA XOR sB.
  - `stage1_exponent` (10-bit signed) = eA + eB − 127.
  - `stage1_mantissa` (48-bit) = {1,fA} × {1,fB}.
  - Special-case flags are computed here.
- **STAGE2: normalize.**
  - If product bit 47 is set, shift right 1 and increment the exponent.
  - `stage2_mantissa` holds 24 significant bits plus guard and sticky bits.
  - `stage2_exponent` and `stage2_sign` carry through.
- **STAGE3: round and pack.**
  - Round per the latched mode:
    - RNE: increment if guard=1 and (sticky=1 or lsb=1).
    - RZ: truncate.
    - +Inf: increment if inexact and sign=0.
    - −Inf: increment if inexact and sign=1.
  - A rounding carry out of the mantissa renormalizes and increments the exponent.
  - Write `result`, pulse `done`, go to IDLE.
- **Special cases (priority order):**
  1. Either operand NaN (exp=FF, frac≠0) → quiet NaN 0x7FC00000.
  2. Inf × zero → 0x7FC00000.
  3. Either operand Inf → signed Inf.
  4. Either operand zero → signed zero.
- **Subnormals are flush-to-zero.**
  - Inputs with exp=0 are treated as zero, with the sign kept.
  - A final biased exponent ≤ 0 after rounding produces signed zero.
- **Overflow** (final biased exponent ≥ 255):
  - RNE → signed Inf.
  - RZ → signed max finite (0x7F7FFFFF / 0xFF7FFFFF).
  - +Inf mode → +Inf if positive, else −max finite.
  - −Inf mode → −Inf if negative, else +max finite.
- **Zero sign:** the sign of a zero result is XOR of the operand signs.

## Timing
- **Reset** (`rst`=0, asynchronous): `state`=IDLE, `result`=0, `done`=0, all stage registers 0.
- **Latency:** `start` sampled at edge N → `result` valid and `done`=1 after edge N+3.
- `done` deasserts at edge N+4.
- `result` is stable from N+3 until the next operation's completion.
- `start` while not in IDLE is ignored; there is no queuing.
- `start` held high continuously begins a new operation on each return to IDLE.
- Operands and mode are latched at acceptance; input changes afterward do not affect the in-flight operation.
- **Reset mid-operation:** the operation is aborted, outputs return to reset values, and no `done` pulse is produced.
- **Throughput:** one operation per 4 cycles (IDLE + 3 stages).

## Test plan
- 0x40200000 (2.5) × 0x40600000 (3.5), RNE → `result`=0x410C0000 (8.75); `done` one cycle, 3 cycles after `start`.
- 0xBFC00000 (−1.5) × 0x40000000 (2.0) → 0xC0400000 (−3.0).
- Specials:
  - 0 × 0x40A00000 → 0x00000000.
  - 0x7F800000 × 0x40000000 → 0x7F800000.
  - 0x7FC00001 × 0x40400000 → exp=FF, frac≠0 (0x7FC00000).
  - 0x7F800000 × 0 → 0x7FC00000.
- Range limits:
  - 0x00800000 × 0x00800000 → 0x00000000 (underflow flush).
  - 0x7F000000 × 0x7F000000, RNE → 0x7F800000.
  - Same operands, RZ → 0x7F7FFFFF.
- Rounding on 0x40266666 (2.6) × 0x3F8CCCCD (1.1):
  - RZ → 0x40370A3D.
  - RNE → 0x40370A3D.
  - +Inf → 0x40370A3E.
  - Negate A with −Inf mode → 0xC0370A3E.
- Handshake and reset:
  - Assert `start` again during STAGE1 → ignored; exactly one `done`.
  - Drop `rst` during STAGE2 → `done`=0, `result`=0, FSM back in IDLE; next `start` completes normally.

Source files
------------

// File: rtl/fp_mul_if.sv
// Request/response bundle for the single-precision multiplier: operands, rounding
// mode and start from the requester; registered product and done pulse back.
`timescale 1ns/1ps
interface fp_mul_if #(
    parameter int D_LEN = 32
);
    logic             start;
    logic [D_LEN-1:0] A;
    logic [D_LEN-1:0] B;
    logic [1:0]       round_mode;
    logic [D_LEN-1:0] result;
    logic             done;

    modport master (
        output start, A, B, round_mode,
        input  result, done
    );

    modport slave (
        input  start, A, B, round_mode,
        output result, done
    );
endinterface

// File: rtl/fp_mul.sv
// Multi-cycle IEEE-754 single-precision multiplier: latch, multiply, normalize,
// round/pack. Subnormals flush to zero; result holds until the next completion.
`timescale 1ns/1ps
module fp_mul #(
    parameter int D_LEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    fp_mul_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, STAGE1, STAGE2, STAGE3} state_t;
    typedef enum logic [1:0] {RND_NE = 2'b00, RND_ZERO = 2'b01, RND_POS = 2'b10, RND_NEG = 2'b11} round_t;
    typedef enum logic [1:0] {SPC_NONE, SPC_QNAN, SPC_INF, SPC_ZERO} special_t;

    state_t               state;
    logic [D_LEN-1:0]     a_q;
    logic [D_LEN-1:0]     b_q;
    round_t               mode_q;

    logic                 stage1_sign;
    logic signed [9:0]    stage1_exponent;
    logic [47:0]          stage1_mantissa;
    special_t             stage1_special;

    logic                 stage2_sign;
    logic signed [9:0]    stage2_exponent;
    logic [25:0]          stage2_mantissa;
    special_t             stage2_special;

    logic [D_LEN-1:0]     result_q;
    logic                 done_q;

    // Operand fields and classification
    logic [7:0]           exp_a;
    logic [7:0]           exp_b;
    logic [22:0]          frac_a;
    logic [22:0]          frac_b;
    logic                 nan_a;
    logic                 nan_b;
    logic                 inf_a;
    logic                 inf_b;
    logic                 zero_a;
    logic                 zero_b;
    special_t             special_c;
    logic [47:0]          product_c;
    logic signed [9:0]    exponent_c;

    assign exp_a  = a_q[30:23];
    assign exp_b  = b_q[30:23];
    assign frac_a = a_q[22:0];
    assign frac_b = b_q[22:0];

    assign nan_a  = (exp_a == 8'hFF) && (frac_a != '0);
    assign nan_b  = (exp_b == 8'hFF) && (frac_b != '0);
    assign inf_a  = (exp_a == 8'hFF) && (frac_a == '0);
    assign inf_b  = (exp_b == 8'hFF) && (frac_b == '0);
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);

    always_comb begin
        special_c = SPC_NONE;
        if (nan_a || nan_b)
            special_c = SPC_QNAN;
        else if ((inf_a && zero_b) || (inf_b && zero_a))
            special_c = SPC_QNAN;
        else if (inf_a || inf_b)
            special_c = SPC_INF;
        else if (zero_a || zero_b)
            special_c = SPC_ZERO;
    end

    assign product_c  = 48'({1'b1, frac_a}) * 48'({1'b1, frac_b});
    assign exponent_c = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;

    // Normalization: product of two [1,2) significands lies in [1,4)
    logic [25:0]          norm_mant;
    logic signed [9:0]    norm_exp;

    always_comb begin
        if (stage1_mantissa[47]) begin
            norm_mant = {stage1_mantissa[47:24], stage1_mantissa[23], |stage1_mantissa[22:0]};
            norm_exp  = stage1_exponent + 10'sd1;
        end else begin
            norm_mant = {stage1_mantissa[46:23], stage1_mantissa[22], |stage1_mantissa[21:0]};
            norm_exp  = stage1_exponent;
        end
    end

    // Rounding and packing; stage2_mantissa = {significand[23:0], guard, sticky}
    logic                 lsb;
    logic                 guard;
    logic                 sticky;
    logic                 inexact;
    logic                 round_up;
    logic [24:0]          rounded;
    logic                 carry;
    logic [22:0]          final_frac;
    logic signed [9:0]    final_exp;
    logic                 overflow_to_inf;
    logic [D_LEN-1:0]     packed_c;

    assign lsb     = stage2_mantissa[2];
    assign guard   = stage2_mantissa[1];
    assign sticky  = stage2_mantissa[0];
    assign inexact = guard | sticky;

    always_comb begin
        round_up = 1'b0;
        case (mode_q)
            RND_NE:   round_up = guard & (sticky | lsb);
            RND_ZERO: round_up = 1'b0;
            RND_POS:  round_up = inexact & ~stage2_sign;
            RND_NEG:  round_up = inexact & stage2_sign;
            default:  round_up = 1'b0;
        endcase
    end

    assign rounded    = {1'b0, stage2_mantissa[25:2]} + 25'(round_up);
    assign carry      = rounded[24];
    assign final_frac = carry ? rounded[23:1] : rounded[22:0];
    assign final_exp  = carry ? (stage2_exponent + 10'sd1) : stage2_exponent;

    // Directed modes saturate to max finite when rounding away from infinity
    assign overflow_to_inf = (mode_q == RND_NE)
                          || ((mode_q == RND_POS) && !stage2_sign)
                          || ((mode_q == RND_NEG) && stage2_sign);

    always_comb begin
        packed_c = '0;
        case (stage2_special)
            SPC_QNAN: packed_c = 32'h7FC00000;
            SPC_INF:  packed_c = {stage2_sign, 8'hFF, 23'h000000};
            SPC_ZERO: packed_c = {stage2_sign, 31'h00000000};
            default: begin
                if (final_exp >= 10'sd255) begin
                    if (overflow_to_inf)
                        packed_c = {stage2_sign, 8'hFF, 23'h000000};
                    else
                        packed_c = {stage2_sign, 8'hFE, 23'h7FFFFF};
                end else if (final_exp <= 10'sd0) begin
                    packed_c = {stage2_sign, 31'h00000000};
                end else begin
                    packed_c = {stage2_sign, final_exp[7:0], final_frac};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            a_q             <= '0;
            b_q             <= '0;
            mode_q          <= RND_NE;
            stage1_sign     <= 1'b0;
            stage1_exponent <= '0;
            stage1_mantissa <= '0;
            stage1_special  <= SPC_NONE;
            stage2_sign     <= 1'b0;
            stage2_exponent <= '0;
            stage2_mantissa <= '0;
            stage2_special  <= SPC_NONE;
            result_q        <= '0;
            done_q          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        mode_q <= round_t'(bus.round_mode);
                        state  <= STAGE1;
                    end
                end
                STAGE1: begin
                    stage1_sign     <= a_q[D_LEN-1] ^ b_q[D_LEN-1];
                    stage1_exponent <= exponent_c;
                    stage1_mantissa <= product_c;
                    stage1_special  <= special_c;
                    state           <= STAGE2;
                end
                STAGE2: begin
                    stage2_sign     <= stage1_sign;
                    stage2_exponent <= norm_exp;
                    stage2_mantissa <= norm_mant;
                    stage2_special  <= stage1_special;
                    state           <= STAGE3;
                end
                STAGE3: begin
                    result_q <= packed_c;
                    done_q   <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_fp_mul.sv
// Self-checking bench for fp_mul: arithmetic reference model plus a per-cycle
// scoreboard on done/result, directed corner cases and random operands.
`timescale 1ns/1ps
module tb_fp_mul;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fp_mul_if #(.D_LEN(32)) bus ();
    fp_mul #(.D_LEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: exact integer significand product, rounded by comparing the
    // discarded remainder against one half ulp.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        logic s;
        int ea, eb, e, shift;
        longint unsigned ma, mb, p, kept, rem, half;
        logic nan_in, inf_in, zero_in, up;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nan_in  = (ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0);
        inf_in  = (ea == 255) || (eb == 255);
        zero_in = (ea == 0) || (eb == 0);
        if (nan_in) return 32'h7FC00000;
        if (inf_in && zero_in) return 32'h7FC00000;
        if (inf_in) return {s, 8'hFF, 23'h0};
        if (zero_in) return {s, 31'h0};
        ma = 64'(a[22:0]) + 64'h800000;
        mb = 64'(b[22:0]) + 64'h800000;
        p  = ma * mb;
        e  = ea + eb - 127;
        shift = (p >= (64'd1 << 47)) ? 24 : 23;
        if (shift == 24) e++;
        kept = p >> shift;
        rem  = p - (kept << shift);
        half = 64'd1 << (shift - 1);
        case (m)
            2'b00:   up = (rem > half) || (rem == half && kept[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = (rem != 0) && !s;
            default: up = (rem != 0) && s;
        endcase
        if (up) kept++;
        if (kept == (64'd1 << 24)) begin
            kept = kept >> 1;
            e++;
        end
        if (e >= 255) begin
            if (m == 2'b00 || (m == 2'b10 && !s) || (m == 2'b11 && s)) return {s, 8'hFF, 23'h0};
            return {s, 8'hFE, 23'h7FFFFF};
        end
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), kept[22:0]};
    endfunction

    // Scoreboard: acceptance tracked from the timing rules (one op per 4 edges)
    typedef struct {
        logic [31:0] res;
        longint      cyc;
    } exp_t;
    exp_t        q[$];
    longint      cyc = 0;
    longint      free_at = 0;
    logic [31:0] held = '0;
    int          done_seen = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            q.delete();
            held    = '0;
            free_at = 0;
        end else begin
            cyc++;
            if (bus.start && cyc >= free_at) begin
                q.push_back('{fp_model(bus.A, bus.B, bus.round_mode), cyc + 3});
                free_at = cyc + 4;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            logic exp_done;
            exp_done = (q.size() > 0) && (q[0].cyc == cyc);
            check("done", 32'(bus.done), 32'(exp_done));
            if (exp_done) begin
                check("result", bus.result, q[0].res);
                held = q[0].res;
                void'(q.pop_front());
            end else begin
                check("result_hold", bus.result, held);
            end
            if (bus.done) done_seen++;
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                          input logic [31:0] exp_r, input bit lit);
        int n;
        bit got;
        @(posedge clk);
        #1;
        bus.A = a; bus.B = b; bus.round_mode = m; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A = $urandom; bus.B = $urandom; bus.round_mode = 2'($urandom);
        got = 1'b0;
        n = 0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            got = bus.done;
        end
        check("latency", 32'(n), 32'd4);
        if (lit) check("directed", bus.result, exp_r);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        int unsigned k;
        r = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0: r[30:0] = '0;
            1: r[30:0] = {8'hFF, 23'h0};
            2: r[30:23] = 8'hFF;
            3: r[30:23] = 8'h00;
            4: r[30:23] = 8'(200 + $urandom_range(0, 54));
            5: r[30:23] = 8'(1 + $urandom_range(0, 40));
            default: r[30:23] = 8'(100 + $urandom_range(0, 54));
        endcase
        return r;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  m;
        logic [31:0] r;
    } vec_t;

    vec_t dir[13] = '{
        '{32'h40200000, 32'h40600000, 2'b00, 32'h410C0000},
        '{32'hBFC00000, 32'h40000000, 2'b00, 32'hC0400000},
        '{32'h00000000, 32'h40A00000, 2'b00, 32'h00000000},
        '{32'h7F800000, 32'h40000000, 2'b00, 32'h7F800000},
        '{32'h7FC00001, 32'h40400000, 2'b00, 32'h7FC00000},
        '{32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000},
        '{32'h00800000, 32'h00800000, 2'b00, 32'h00000000},
        '{32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000},
        '{32'h7F000000, 32'h7F000000, 2'b01, 32'h7F7FFFFF},
        '{32'h40266666, 32'h3F8CCCCD, 2'b01, 32'h40370A3D},
        '{32'h40266666, 32'h3F8CCCCD, 2'b00, 32'h40370A3D},
        '{32'h40266666, 32'h3F8CCCCD, 2'b10, 32'h40370A3E},
        '{32'hC0266666, 32'h3F8CCCCD, 2'b11, 32'hC0370A3E}
    };

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.round_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", bus.result, 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        check("model_basic", fp_model(32'h40200000, 32'h40600000, 2'b00), 32'h410C0000);
        check("model_rup", fp_model(32'h40266666, 32'h3F8CCCCD, 2'b10), 32'h40370A3E);
        check("model_ovf_rz", fp_model(32'h7F000000, 32'h7F000000, 2'b01), 32'h7F7FFFFF);
        check("model_inf_zero", fp_model(32'h7F800000, 32'h00000000, 2'b00), 32'h7FC00000);

        foreach (dir[i]) run_op(dir[i].a, dir[i].b, dir[i].m, dir[i].r, 1'b1);

        for (int i = 0; i < 150; i++) run_op(rand_fp(), rand_fp(), 2'($urandom), 32'h0, 1'b0);

        // start held high: a new operation on every return to IDLE
        base = done_seen;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        repeat (13) begin
            bus.A = rand_fp(); bus.B = rand_fp(); bus.round_mode = 2'($urandom);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("held_start_count", 32'(done_seen - base), 32'd4);

        // start repeated while in STAGE1 is ignored
        base = done_seen;
        @(posedge clk);
        #1;
        bus.A = 32'h40200000; bus.B = 32'h40600000; bus.round_mode = 2'b00; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.A = 32'h3F800000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("stage1_start_count", 32'(done_seen - base), 32'd1);
        check("stage1_start_result", bus.result, 32'h410C0000);

        // reset while in STAGE2 aborts without a done pulse
        base = done_seen;
        @(posedge clk);
        #1;
        bus.A = 32'h40266666; bus.B = 32'h3F8CCCCD; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_result", bus.result, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_seen - base), 32'd0);
        run_op(32'h40200000, 32'h40600000, 2'b00, 32'h410C0000, 1'b1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
